// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: queues operand pairs, feeds them serially to a
// subtraction-based GCD core and returns each result in input order.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a queued pair; zero operands resolved here
// CRST   | one-cycle clear of the core, core_data = A
// LOAD_A | one-cycle start pulse, core loads A
// LOAD_B | core loads B, timeout timer cleared
// WAIT   | waiting for core_done or timeout
// OUT    | result held on the output stream until accepted
module gcd_job_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_gcd_o,
    output logic             out_err_o,
    output logic             core_rst_o,
    output logic             core_start_o,
    output logic [WIDTH-1:0] core_data_o,
    input  logic [WIDTH-1:0] core_result_i,
    input  logic             core_done_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_OUT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] out_gcd_q;
    logic             out_valid_q;
    logic             out_err_q;
    logic             core_rst_q;
    logic             core_start_q;
    logic [WIDTH-1:0] core_data_q;
    logic [TW-1:0]    timer_q;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push   = in_valid_i && !full;
    assign pop    = (state_q == S_IDLE) && !empty && !out_valid_q;
    assign head_a = mem_a_q[rd_ptr_q[AW-1:0]];
    assign head_b = mem_b_q[rd_ptr_q[AW-1:0]];

    assign in_ready_o   = !full;
    assign out_valid_o  = out_valid_q;
    assign out_gcd_o    = out_gcd_q;
    assign out_err_o    = out_err_q;
    assign core_rst_o   = core_rst_q;
    assign core_start_o = core_start_q;
    assign core_data_o  = core_data_q;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a_q[wr_ptr_q[AW-1:0]] <= in_a_i;
            mem_b_q[wr_ptr_q[AW-1:0]] <= in_b_i;
        end
    end

    // FIFO pointers, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Job sequencing FSM with all stream and core-side outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            out_valid_q  <= 1'b0;
            out_gcd_q    <= '0;
            out_err_q    <= 1'b0;
            core_rst_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_data_q  <= '0;
            timer_q      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        op_a_q <= head_a;
                        op_b_q <= head_b;
                        // The subtraction core never terminates on a zero operand.
                        if (head_a == '0 || head_b == '0) begin
                            out_gcd_q   <= head_a | head_b;
                            out_err_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_OUT;
                        end else begin
                            core_rst_q  <= 1'b1;
                            core_data_q <= head_a;
                            state_q     <= S_CRST;
                        end
                    end
                end
                S_CRST: begin
                    core_rst_q   <= 1'b0;
                    core_start_q <= 1'b1;
                    core_data_q  <= op_a_q;
                    state_q      <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    core_start_q <= 1'b0;
                    core_data_q  <= op_b_q;
                    state_q      <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // done is checked first so it wins over a coincident timeout
                    if (core_done_i) begin
                        out_gcd_q   <= core_result_i;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        out_gcd_q   <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
